// File: rtl/itcm_arbiter_pkg.sv
// Shared ITCM definitions: the access-owner encoding and the ITCM data width.
package itcm_arbiter_pkg;

   localparam int DATA_W = 64;
   localparam int MASK_W = DATA_W / 8;

   typedef enum logic [1:0] {
      OWN_NONE   = 2'd0,
      OWN_IFU_RD = 2'd1,
      OWN_LSU_RD = 2'd2,
      OWN_LSU_WR = 2'd3
   } owner_e;

endpackage

// File: rtl/itcm_arbiter.sv
// Two-port ITCM arbiter: LSU-priority grant with IFU anti-starvation, single-cycle
// SRAM access, response one cycle after grant routed by the registered owner.
//
// state      | meaning
// OWN_NONE   | no access granted last cycle, no response this cycle
// OWN_IFU_RD | IFU read granted last cycle, fetch data returns now
// OWN_LSU_RD | LSU read granted last cycle, load data returns now
// OWN_LSU_WR | LSU write granted last cycle, write ack returns now
module itcm_arbiter
   import itcm_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 14,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                cpurst_n,

   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_req_addr,
   output logic                ifu_rsp_valid,
   output logic [DATA_W-1:0]   ifu_rsp_data,
   input  logic                ifu_flush,

   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_req_addr,
   input  logic                lsu_req_wen,
   input  logic [DATA_W-1:0]   lsu_req_wdata,
   input  logic [MASK_W-1:0]   lsu_req_wmask,
   output logic                lsu_rsp_valid,
   output logic [DATA_W-1:0]   lsu_rsp_data,

   output logic                sram_cs,
   output logic                sram_we,
   output logic [ADDR_W-4:0]   sram_addr,
   output logic [DATA_W-1:0]   sram_wdata,
   output logic [MASK_W-1:0]   sram_wem,
   input  logic [DATA_W-1:0]   sram_rdata
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   owner_e             owner;
   logic               ifu_drop;
   logic [CNT_W-1:0]   starve_cnt;
   logic               starved;
   logic               ifu_win;
   logic               lsu_win;
   logic               unused_addr_lsbs;

   // Grants are held off while in reset so no strobe leaks onto the SRAM.
   assign starved = (starve_cnt == CNT_W'(STARVE_MAX));
   assign ifu_win = cpurst_n && ifu_req_valid && (!lsu_req_valid || starved);
   assign lsu_win = cpurst_n && lsu_req_valid && !ifu_win;

   assign ifu_req_ready = ifu_win;
   assign lsu_req_ready = lsu_win;

   assign sram_cs    = ifu_win || lsu_win;
   assign sram_we    = lsu_win && lsu_req_wen;
   assign sram_addr  = lsu_win ? lsu_req_addr[ADDR_W-1:3] : ifu_req_addr[ADDR_W-1:3];
   assign sram_wdata = sram_we ? lsu_req_wdata : '0;
   assign sram_wem   = sram_we ? lsu_req_wmask : '0;

   assign unused_addr_lsbs = ^{ifu_req_addr[2:0], lsu_req_addr[2:0]};

   always_ff @(posedge clk or negedge cpurst_n) begin
      if (!cpurst_n) begin
         owner      <= OWN_NONE;
         ifu_drop   <= 1'b0;
         starve_cnt <= '0;
      end else begin
         if (ifu_win)
            owner <= OWN_IFU_RD;
         else if (lsu_win)
            owner <= lsu_req_wen ? OWN_LSU_WR : OWN_LSU_RD;
         else
            owner <= OWN_NONE;

         // A flush seen alongside the grant kills the fetch that is still in flight.
         ifu_drop <= ifu_win && ifu_flush;

         if (ifu_req_valid && !ifu_win) begin
            if (!starved)
               starve_cnt <= starve_cnt + CNT_W'(1);
         end else begin
            starve_cnt <= '0;
         end
      end
   end

   assign ifu_rsp_valid = (owner == OWN_IFU_RD) && !ifu_drop && !ifu_flush;
   assign ifu_rsp_data  = ifu_rsp_valid ? sram_rdata : '0;
   assign lsu_rsp_valid = (owner == OWN_LSU_RD) || (owner == OWN_LSU_WR);
   assign lsu_rsp_data  = (owner == OWN_LSU_RD) ? sram_rdata : '0;

endmodule

// File: tb/tb_itcm_arbiter.sv
// Bench for itcm_arbiter: directed scenarios plus random traffic, with a memory
// reference model and a response scoreboard drained by an independent monitor.
module tb_itcm_arbiter;

   localparam int ADDR_W     = 14;
   localparam int STARVE_MAX = 4;
   localparam int DEPTH      = 1 << (ADDR_W - 3);

   logic                clk = 1'b0;
   logic                cpurst_n;
   logic                ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_flush;
   logic [ADDR_W-1:0]   ifu_req_addr;
   logic [63:0]         ifu_rsp_data;
   logic                lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid;
   logic [ADDR_W-1:0]   lsu_req_addr;
   logic [63:0]         lsu_req_wdata, lsu_rsp_data;
   logic [7:0]          lsu_req_wmask;
   logic                sram_cs, sram_we;
   logic [ADDR_W-4:0]   sram_addr;
   logic [63:0]         sram_wdata, sram_rdata;
   logic [7:0]          sram_wem;

   itcm_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .cpurst_n(cpurst_n),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
      .ifu_req_addr(ifu_req_addr), .ifu_rsp_valid(ifu_rsp_valid),
      .ifu_rsp_data(ifu_rsp_data), .ifu_flush(ifu_flush),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
      .lsu_req_addr(lsu_req_addr), .lsu_req_wen(lsu_req_wen),
      .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
      .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
      .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_wem(sram_wem), .sram_rdata(sram_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // External ITCM: one-cycle read latency, byte-masked writes, garbage when idle.
   logic [63:0] mem [DEPTH];
   always @(posedge clk) begin
      if (sram_cs && sram_we) begin
         for (int b = 0; b < 8; b++)
            if (sram_wem[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
         sram_rdata <= {$urandom, $urandom};
      end else if (sram_cs) begin
         sram_rdata <= mem[sram_addr];
      end else begin
         sram_rdata <= {$urandom, $urandom};
      end
   end

   typedef struct {
      int          due;
      bit          flush_g;
      logic [63:0] data;
   } rsp_t;

   rsp_t        ifu_q[$];
   rsp_t        lsu_q[$];
   logic [63:0] ref_mem [DEPTH];
   int          ifu_wait = 0;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   // One bus cycle: drive requests, check grant and SRAM strobes, queue expected responses.
   task automatic step(input bit iv, input logic [ADDR_W-1:0] ia, input bit lv,
                       input logic [ADDR_W-1:0] la, input bit we, input logic [63:0] wd,
                       input logic [7:0] wm, input bit fl);
      bit   exp_ig, exp_lg;
      int   idx;
      rsp_t r;
      @(negedge clk);
      ifu_req_valid = iv;  ifu_req_addr = ia;  ifu_flush = fl;
      lsu_req_valid = lv;  lsu_req_addr = la;  lsu_req_wen = we;
      lsu_req_wdata = wd;  lsu_req_wmask = wm;
      #1;
      exp_ig = iv && (!lv || ifu_wait >= STARVE_MAX);
      exp_lg = lv && !exp_ig;
      chk("ifu_req_ready", ifu_req_ready, exp_ig);
      chk("lsu_req_ready", lsu_req_ready, exp_lg);
      chk("sram_cs", sram_cs, exp_ig || exp_lg);
      if (exp_ig) begin
         idx = int'(ia) / 8;
         chk("sram_addr_ifu", sram_addr, idx);
         chk("sram_we_ifu", sram_we, 0);
         chk("sram_wem_ifu", sram_wem, 0);
         r.due = cyc + 1;  r.flush_g = fl;  r.data = ref_mem[idx];
         ifu_q.push_back(r);
      end else if (exp_lg) begin
         idx = int'(la) / 8;
         chk("sram_addr_lsu", sram_addr, idx);
         chk("sram_we_lsu", sram_we, we);
         chk("sram_wem_lsu", sram_wem, we ? wm : 8'h00);
         r.due = cyc + 1;  r.flush_g = 1'b0;  r.data = we ? 64'h0 : ref_mem[idx];
         lsu_q.push_back(r);
         if (we) begin
            chk("sram_wdata", sram_wdata, wd);
            for (int b = 0; b < 8; b++)
               if (wm[b]) ref_mem[idx][b*8 +: 8] = wd[b*8 +: 8];
         end
      end else begin
         chk("sram_we_idle", sram_we, 0);
      end
      if (iv && !exp_ig) ifu_wait = (ifu_wait < STARVE_MAX) ? ifu_wait + 1 : STARVE_MAX;
      else               ifu_wait = 0;
   endtask

   task automatic idle(input bit fl);
      step(0, '0, 0, '0, 0, 64'h0, 8'h00, fl);
   endtask

   task automatic do_reset();
      @(negedge clk);
      cpurst_n = 1'b0;
      ifu_q.delete();
      lsu_q.delete();
      ifu_wait = 0;
      ifu_req_valid = 1'b1;
      lsu_req_valid = 1'b1;
      lsu_req_wen   = 1'b1;
      ifu_flush     = 1'b0;
      #1;
      chk("rst_sram_cs", sram_cs, 0);
      chk("rst_sram_we", sram_we, 0);
      chk("rst_ifu_ready", ifu_req_ready, 0);
      chk("rst_lsu_ready", lsu_req_ready, 0);
      chk("rst_lsu_rsp_valid", lsu_rsp_valid, 0);
      chk("rst_ifu_rsp_valid", ifu_rsp_valid, 0);
      repeat (2) @(negedge clk);
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      lsu_req_wen   = 1'b0;
      @(negedge clk);
      cpurst_n = 1'b1;
   endtask

   // Response monitor: every cycle, outputs must match exactly what is due (or be idle).
   always @(negedge clk) begin
      bit          e_iv, e_lv;
      logic [63:0] e_id, e_ld;
      rsp_t        r;
      #2;
      e_iv = 1'b0;  e_id = '0;  e_lv = 1'b0;  e_ld = '0;
      while (ifu_q.size() > 0 && ifu_q[0].due < cyc) void'(ifu_q.pop_front());
      while (lsu_q.size() > 0 && lsu_q[0].due < cyc) void'(lsu_q.pop_front());
      if (ifu_q.size() > 0 && ifu_q[0].due == cyc) begin
         r = ifu_q.pop_front();
         if (!r.flush_g && !ifu_flush) begin
            e_iv = 1'b1;
            e_id = r.data;
         end
      end
      if (lsu_q.size() > 0 && lsu_q[0].due == cyc) begin
         r = lsu_q.pop_front();
         e_lv = 1'b1;
         e_ld = r.data;
      end
      chk("ifu_rsp_valid", ifu_rsp_valid, e_iv);
      chk("ifu_rsp_data", ifu_rsp_data, e_id);
      chk("lsu_rsp_valid", lsu_rsp_valid, e_lv);
      chk("lsu_rsp_data", lsu_rsp_data, e_ld);
   end

   initial begin
      logic [63:0] v;
      for (int i = 0; i < DEPTH; i++) begin
         v = {$urandom, $urandom};
         mem[i] = v;
         ref_mem[i] = v;
      end
      cpurst_n = 1'b0;
      ifu_req_valid = 0; ifu_req_addr = '0; ifu_flush = 0;
      lsu_req_valid = 0; lsu_req_addr = '0; lsu_req_wen = 0;
      lsu_req_wdata = '0; lsu_req_wmask = '0;
      repeat (2) @(negedge clk);
      do_reset();

      // lone fetch of 0x0010 -> doubleword 2
      step(1, 14'h0010, 0, '0, 0, 64'h0, 8'h00, 0);
      idle(0);

      // partial write then fetch of the same doubleword
      step(0, '0, 1, 14'h0008, 1, 64'h1122334455667788, 8'h0F, 0);
      step(1, 14'h0008, 0, '0, 0, 64'h0, 8'h00, 0);
      idle(0);

      // both requesters saturating: 4 LSU grants, then IFU, repeating
      for (int i = 0; i < 15; i++)
         step(1, 14'($urandom), 1, 14'($urandom), 0, 64'h0, 8'h00, 0);
      idle(0);

      // flush in the response cycle, then flush in the grant cycle
      step(1, 14'h0020, 0, '0, 0, 64'h0, 8'h00, 0);
      idle(1);
      step(1, 14'h0028, 0, '0, 0, 64'h0, 8'h00, 1);
      idle(0);

      // reset one cycle after an LSU read grant, with the IFU already starving
      step(1, 14'h0030, 1, 14'h0040, 0, 64'h0, 8'h00, 0);
      step(1, 14'h0030, 1, 14'h0048, 0, 64'h0, 8'h00, 0);
      step(1, 14'h0030, 1, 14'h0050, 0, 64'h0, 8'h00, 0);
      do_reset();
      idle(0);
      for (int i = 0; i < 10; i++)
         step(1, 14'($urandom), 1, 14'($urandom), 0, 64'h0, 8'h00, 0);
      idle(0);

      // back-to-back LSU reads
      step(0, '0, 1, 14'h0000, 0, 64'h0, 8'h00, 0);
      step(0, '0, 1, 14'h0008, 0, 64'h0, 8'h00, 0);
      step(0, '0, 1, 14'h0010, 0, 64'h0, 8'h00, 0);
      idle(0);

      // random traffic over a small window so reads hit earlier writes
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 3) != 0, 14'($urandom_range(0, 255)),
              $urandom_range(0, 2) != 0, 14'($urandom_range(0, 255)),
              $urandom_range(0, 1) == 1, {$urandom, $urandom}, 8'($urandom),
              $urandom_range(0, 9) == 0);
      idle(0);
      idle(0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/itcm_arbiter.md
ITCM_ARBITER -- requirements
Module: itcm_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, the byte-address width covering a 16 KiB ITCM.
REQ-002 SHALL have parameter STARVE_MAX, default 4, the number of consecutive denied IFU cycles before the IFU is forced to win.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 SHALL have port cpurst_n, input, 1 bit, an asynchronous active-low reset.
REQ-005 SHALL have port ifu_req_valid, input, 1 bit, the fetch request.
REQ-006 SHALL have port ifu_req_ready, output, 1 bit, the fetch grant.
REQ-007 SHALL have port ifu_req_addr, input, ADDR_W bits, the fetch byte address.
REQ-008 SHALL have port ifu_rsp_valid, output, 1 bit, the fetch data valid.
REQ-009 SHALL have port ifu_rsp_data, output, 64 bits, the fetch doubleword.
REQ-010 SHALL have port ifu_flush, input, 1 bit, which discards an in-flight fetch response.
REQ-011 SHALL have port lsu_req_valid, input, 1 bit, the load/store or loader request.
REQ-012 SHALL have port lsu_req_ready, output, 1 bit, the LSU grant.
REQ-013 SHALL have port lsu_req_addr, input, ADDR_W bits, the LSU byte address.
REQ-014 SHALL have port lsu_req_wen, input, 1 bit, where 1 means write.
REQ-015 SHALL have port lsu_req_wdata, input, 64 bits, the write data.
REQ-016 SHALL have port lsu_req_wmask, input, 8 bits, the byte enables.
REQ-017 SHALL have port lsu_rsp_valid, output, 1 bit, the read data or write acknowledge.
REQ-018 SHALL have port lsu_rsp_data, output, 64 bits, the read data.
REQ-019 SHALL have ports sram_cs and sram_we, outputs, 1 bit each, the ITCM strobes.
REQ-020 SHALL have port sram_addr, output, ADDR_W-3 bits, the doubleword index.
REQ-021 SHALL have ports sram_wdata (64 bits) and sram_wem (8 bits), outputs, the write data and byte mask.
REQ-022 SHALL have port sram_rdata, input, 64 bits, valid one cycle after a read with sram_cs asserted.

Function
REQ-023 SHALL grant at most one requester per cycle; a request completes in the cycle where valid and ready are both 1.
REQ-024 SHALL drive ready combinationally from the valids and the starvation counter; valid is never gated by ready.
REQ-025 SHALL give the LSU priority by default.
REQ-026 SHALL give the IFU the win when starve_cnt equals STARVE_MAX.
REQ-027 SHALL increment starve_cnt, saturating at STARVE_MAX, on each cycle where ifu_req_valid=1 and ifu_req_ready=0.
REQ-028 SHALL clear starve_cnt on an IFU grant or when ifu_req_valid=0.
REQ-029 SHALL, on a grant, drive sram_cs=1 and sram_addr=addr[ADDR_W-1:3] in the same cycle; addr[2:0] is ignored.
REQ-030 SHALL drive sram_we=lsu_req_wen and sram_wem=wmask on an LSU grant, and sram_wem=0 on reads.
REQ-031 SHALL register the owner as one of NONE, IFU_RD, LSU_RD or LSU_WR; this register is the response FSM, reloaded every cycle.
REQ-032 SHALL return a read response exactly 1 cycle after the grant, with rsp_valid=1 and rsp_data=sram_rdata to the owner only.
REQ-033 SHALL acknowledge an LSU write 1 cycle after the grant with lsu_rsp_valid=1 and lsu_rsp_data=0.
REQ-034 SHALL assume responses are never back-pressured, supporting a new grant every cycle for a sustained throughput of 1 access/cycle.
REQ-035 SHALL suppress ifu_rsp_valid when ifu_flush=1 in the response cycle, or when ifu_flush=1 in the grant cycle; the SRAM read still occurs.
REQ-036 SHALL drive rsp_data to 0 whenever the matching rsp_valid=0.
REQ-037 SHALL grant the LSU on simultaneous requests with starve_cnt<STARVE_MAX, and the IFU otherwise.

Reset
REQ-038 SHALL, while cpurst_n=0, asynchronously clear owner to NONE and starve_cnt to 0, with all rsp_valid, sram_cs and sram_we outputs at 0.
REQ-039 SHALL discard a response pending at reset assertion, and never emit it after release.
REQ-040 SHALL accept grants from the first rising edge after reset release.

Structure
REQ-041 SHALL place the owner encoding (NONE=0, IFU_RD=1, LSU_RD=2, LSU_WR=3) and the ITCM data width of 64 in a shared core package.
REQ-042 SHALL be a single module with no sub-modules; the SRAM instance stays outside.

Verification
REQ-043 SHALL cover a lone IFU read of addr 0x0010 -> sram_addr=0x002 with cs=1 in cycle N, and ifu_rsp_valid=1 with the data of mem[2] in cycle N+1.
REQ-044 SHALL cover an LSU write of addr 0x0008, wdata 0x1122334455667788, wmask 0x0F, followed by an IFU read of 0x0008 -> low 4 bytes 0x55667788, high bytes preserved.
REQ-045 SHALL cover IFU and LSU both valid continuously -> LSU granted 4 cycles, IFU granted on the 5th, then LSU 4 cycles, repeating.
REQ-046 SHALL cover ifu_flush=1 in the response cycle -> ifu_rsp_valid=0 and no LSU response generated.
REQ-047 SHALL cover cpurst_n asserted one cycle after an LSU read grant -> no lsu_rsp_valid before or after release, and starve_cnt=0.
REQ-048 SHALL cover back-to-back LSU reads of 0x00,0x08,0x10 -> three consecutive lsu_rsp_valid cycles with in-order data.
